if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Instruction-fetch controller for the 5-stage pipeline. It owns the program counter, runs a req/ack handshake to instruction memory, and produces the PC/instruction pair that is written into the IF/ID pipeline register. It also drives that register's clock-enable, absorbs ID-stage stalls in a one-entry hold buffer, and applies branch redirects, draining any in-flight memory access first.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall_id  in  1  ID stage cannot accept a new instruction this cycle
- branch_taken  in  1  single-cycle redirect request
- branch_target  in  32  redirect PC, word aligned
- imem_req  out  1  memory request, held until ack
- imem_addr  out  32  request address, stable while imem_req=1
- imem_ack  in  1  read data valid; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_pc  out  32  PC presented to the IF/ID register
- if_inst  out  32  instruction presented to the IF/ID register
- if_valid  out  1  if_inst is a real instruction, not a bubble
- ifid_ce  out  1  IF/ID register clock-enable

## Operation
- State register values: IDLE, FETCH, HOLD, DRAIN.
  - pc register: 32 bits.
  - hold buffer: 32-bit instruction, 32-bit PC, valid bit.
  - tgt register: saved redirect PC.
- ifid_ce = ~stall_id, combinationally, in every state.
- IDLE: entered on reset. Moves to FETCH on the first clock edge after rst deasserts.
- FETCH: imem_req=1, imem_addr=pc.
  - ack, no branch, stall_id=0: present {pc, rdata} with if_valid=1. pc <= pc+4. Stay in FETCH, so back-to-back fetch continues.
  - ack, no branch, stall_id=1: capture {pc, rdata} into the hold buffer. pc <= pc+4. Go to HOLD.
  - no ack: present a bubble. Stay in FETCH.
- HOLD: imem_req=0. Present the hold buffer with if_valid=1.
  - When stall_id=0: the buffer is consumed that edge and the state goes to FETCH.
- DRAIN: imem_req=1 at the old address. No output.
  - On ack: discard the data, pc <= tgt, go to FETCH.
- Bubble: if_pc=pc, if_inst=NOP_INST, if_valid=0.
- PC arithmetic: 32-bit, +4, wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). branch_target[1:0] is ignored and forced to 0.
- branch_taken has the highest priority and is honoured regardless of stall_id. The instruction currently presented is squashed: if_valid=0, if_inst=NOP_INST that cycle.
  - FETCH with ack in the same cycle: drop the data, pc <= target, stay in FETCH.
  - FETCH without ack: tgt <= target, go to DRAIN. The request cannot be withdrawn.
  - HOLD: clear the hold buffer, pc <= target, go to FETCH.
  - DRAIN: tgt <= target, so the latest redirect wins.
  - IDLE: pc <= target.
- Reset mid-operation: all state clears immediately. An outstanding memory access is abandoned; the memory is reset by the same rst.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - if_pc=RESET_PC, if_inst=NOP_INST, if_valid=0
  - state=IDLE, hold buffer empty
- imem_req and imem_addr are decoded from registered state only, with no combinational path from imem_ack.
- if_pc, if_inst and if_valid may depend combinationally on imem_ack/imem_rdata in FETCH. This is the zero-wait path.
- Throughput with a zero-wait memory: 1 instruction/cycle.
- Latency: redirect to first target request is 1 cycle, plus the residual wait of any drain.
- A stall release out of HOLD costs 1 cycle (the re-request); no instruction is lost or duplicated.

## Configuration
- IF_FETCH_PERF_EN defined: adds two 32-bit outputs.
  - perf_fetch_cnt: increments each cycle with ifid_ce & if_valid.
  - perf_bubble_cnt: increments each cycle with ifid_ce & ~if_valid.
  - Both reset to 0 and wrap.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

## Structure
- Shared package if_pkg: the state enum (IDLE/FETCH/HOLD/DRAIN), the PC_INC=4 constant and the NOP_INST default.
- Sub-module if_perf_ctr holds the two counters. It is instantiated only under IF_FETCH_PERF_EN.

## Test plan
- Zero-wait memory returning addr as data, stall_id=0 throughout -> if_pc 0,4,8,12 on consecutive cycles with if_valid=1 and if_inst equal to the PC.
- Memory with 2-cycle ack latency -> each real instruction is preceded by 2 bubbles (NOP_INST, if_valid=0), and imem_addr stays stable while imem_req=1.
- stall_id=1 for 3 cycles at the cycle that returns PC 8 -> FSM in HOLD, ifid_ce=0, if_pc=8 held. On release the next delivery is PC 8 once, then PC 12.
- branch_taken with target 32'h100 while a 3-cycle access to PC 4 is pending -> FSM in DRAIN. The PC 4 data is never presented with if_valid=1, and the next request address is 32'h100.
- pc=32'hFFFF_FFFC fetched -> next imem_addr is 32'h0.
- rst asserted while in DRAIN -> imem_req drops to 0 immediately; after release the first request is at RESET_PC. With IF_FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC           = XLEN'(4);
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = '0;  // sll $0,$0,0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory req/ack bus between the fetch controller and imem.
interface if_fetch_ctrl_if;
  import if_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_perf_ctr.sv
// Fetch/bubble event counters; only present when IF_FETCH_PERF_EN is defined.
`ifdef IF_FETCH_PERF_EN
module if_perf_ctr
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            vld,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] bubble_cnt
);

  // Count IF/ID writes split by real instruction vs bubble; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (ce) begin
      if (vld) fetch_cnt  <= fetch_cnt + XLEN'(1);
      else     bubble_cnt <= bubble_cnt + XLEN'(1);
    end
  end

endmodule
`endif

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC ownership, imem req/ack, IF/ID hold buffer
// and branch redirect with drain. Optional counters under IF_FETCH_PERF_EN.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_id,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  if_fetch_ctrl_if.master   imem,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_inst,
  output logic              if_valid,
  output logic              ifid_ce
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [XLEN-1:0]   perf_fetch_cnt,
  output logic [XLEN-1:0]   perf_bubble_cnt
`endif
);

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] tgt, tgt_d;
  logic [XLEN-1:0] hold_inst, hold_inst_d;
  logic [XLEN-1:0] hold_pc, hold_pc_d;
  logic            hold_vld, hold_vld_d;
  logic [XLEN-1:0] tgt_aligned;

  assign tgt_aligned = branch_target & ~XLEN'(3);
  assign ifid_ce     = ~stall_id;

  // Memory request comes from registered state only; address is the live PC.
  assign imem.imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem.imem_addr = pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // PC, redirect target and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      tgt       <= RESET_PC;
      hold_inst <= NOP_INST;
      hold_pc   <= RESET_PC;
      hold_vld  <= 1'b0;
    end else begin
      pc        <= pc_d;
      tgt       <= tgt_d;
      hold_inst <= hold_inst_d;
      hold_pc   <= hold_pc_d;
      hold_vld  <= hold_vld_d;
    end
  end

  // Next state and IF/ID payload; a redirect always squashes this cycle's output.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    tgt_d       = tgt;
    hold_inst_d = hold_inst;
    hold_pc_d   = hold_pc;
    hold_vld_d  = hold_vld;
    if_pc       = pc;
    if_inst     = NOP_INST;
    if_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = FETCH;
        if (branch_taken) pc_d = tgt_aligned;
      end
      FETCH: begin
        if (branch_taken) begin
          if (imem.imem_ack) begin
            pc_d = tgt_aligned;
          end else begin
            tgt_d   = tgt_aligned;
            state_d = DRAIN;
          end
        end else if (imem.imem_ack) begin
          pc_d = pc + PC_INC;
          if (stall_id) begin
            hold_inst_d = imem.imem_rdata;
            hold_pc_d   = pc;
            hold_vld_d  = 1'b1;
            state_d     = HOLD;
          end else begin
            if_inst  = imem.imem_rdata;
            if_valid = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          hold_vld_d = 1'b0;
          pc_d       = tgt_aligned;
          state_d    = FETCH;
        end else begin
          if_pc    = hold_pc;
          if_inst  = hold_inst;
          if_valid = hold_vld;
          if (!stall_id) begin
            hold_vld_d = 1'b0;
            state_d    = FETCH;
          end
        end
      end
      DRAIN: begin
        if (branch_taken) tgt_d = tgt_aligned;
        if (imem.imem_ack) begin
          pc_d    = branch_taken ? tgt_aligned : tgt;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IF_FETCH_PERF_EN
  if_perf_ctr u_perf (
    .clk        (clk),
    .rst        (rst),
    .ce         (ifid_ce),
    .vld        (if_valid),
    .fetch_cnt  (perf_fetch_cnt),
    .bubble_cnt (perf_bubble_cnt)
  );
`endif

endmodule
